// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scan driver.
// Used by seg_scan_driver and seg_blink_gen.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned FRAME_W    = NUM_DIGITS * 8;

    localparam logic [7:0] SEG_BLANK  = 8'h00;
    localparam logic [7:0] EN_ALL_OFF = 8'hFF;

    // Digit index, 0..NUM_DIGITS-1.
    typedef logic [2:0] digit_t;

    localparam digit_t LAST_DIGIT = digit_t'(NUM_DIGITS - 1);

    // Per-slot phase: all digits dark (anti-ghosting gap), or one digit lit.
    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_SHOW  = 1'b1
    } slot_t;

    // Active-low one-cold enable for the given digit.
    function automatic logic [7:0] digit_enable(digit_t d);
        return ~(8'b0000_0001 << d);
    endfunction

endpackage

// File: rtl/seg_blink_gen.sv
// seg_blink_gen: free-running blink phase generator.
// blink_phase starts at 1 after reset and toggles every BLINK_DIV cycles.
module seg_blink_gen
    import seg_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    output logic blink_phase
);

    localparam int unsigned DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Count BLINK_DIV cycles per half-period and flip the phase on each wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            blink_phase <= 1'b1;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt     <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            div_cnt     <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: eight-digit time-multiplexed seven-segment scan driver.
// Frames arrive over valid/ready into a pending buffer and are promoted to
// the active buffer only at a scan-frame boundary, so a scan never tears.
// Each digit slot starts with BLANK_CYC dark cycles to suppress ghosting.
// Optional feature: define SEG_BLINK_EN to add the blink_mask port and
// per-digit blinking driven by seg_blink_gen.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 1000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame,
    input  logic               frame_valid,
    output logic               frame_ready,
`ifdef SEG_BLINK_EN
    input  logic [7:0]         blink_mask,
`endif
    output logic [7:0]         seg_en,
    output logic [7:0]         seg_out,
    output logic               frame_done
);

    localparam int unsigned     CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    logic [FRAME_W-1:0] active;
    logic [FRAME_W-1:0] pending;
    logic               pend_full;
    logic [CNT_W-1:0]   cnt;
    digit_t             digit;

    logic               cnt_wrap;
    logic               frame_boundary;
    logic               accept;
    logic [7:0]         show_byte;
    logic               blink_hide;
    slot_t              slot;

    assign cnt_wrap       = (cnt == CNT_MAX);
    assign frame_boundary = cnt_wrap && (digit == LAST_DIGIT);
    assign frame_done     = frame_boundary;
    assign frame_ready    = !pend_full;
    assign accept         = frame_valid && frame_ready;
    assign show_byte      = active[{digit, 3'b000} +: 8];

`ifdef SEG_BLINK_EN
    logic blink_phase;

    seg_blink_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk         (clk),
        .rst         (rst),
        .blink_phase (blink_phase)
    );

    assign blink_hide = !blink_phase && blink_mask[digit];
`else
    // Blinking is not built; only a meaningless zero divider could set this.
    assign blink_hide = (BLINK_DIV == 0);
`endif

    // Decode the slot phase from the position inside the digit slot.
    always_comb begin
        slot = SLOT_SHOW;
        if (cnt < BLANK_LIM) begin
            slot = SLOT_BLANK;
        end
    end

    // Double buffer: a handshake fills pending; a frame boundary promotes it.
    // accept requires pend_full = 0, so accept and promotion never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= '0;
            pending   <= '0;
            pend_full <= 1'b0;
        end else if (accept) begin
            pending   <= frame;
            pend_full <= 1'b1;
        end else if (frame_boundary && pend_full) begin
            active    <= pending;
            pend_full <= 1'b0;
        end
    end

    // Slot FSM: advance the slot counter and digit, register the drive outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            digit   <= '0;
            seg_en  <= EN_ALL_OFF;
            seg_out <= SEG_BLANK;
        end else begin
            if (cnt_wrap) begin
                cnt   <= '0;
                digit <= digit + 3'd1;
            end else begin
                cnt   <= cnt + 1'b1;
            end

            case (slot)
                SLOT_BLANK: begin
                    seg_en  <= EN_ALL_OFF;
                    seg_out <= SEG_BLANK;
                end
                default: begin
                    seg_en  <= digit_enable(digit);
                    seg_out <= blink_hide ? SEG_BLANK : show_byte;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: self-checking bench for seg_scan_driver.
// A cycle-indexed model derives expected outputs from the scan timing rules;
// directed checks pin individual cycles with literal values.
// Define SEG_BLINK_EN for both DUT and bench to exercise blinking.
module tb_seg_scan_driver;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int BLINK_DIV = 64;
    localparam int FRAME_CYC = 8 * SCAN_DIV;

    logic        clk;
    logic        rst;
    logic [63:0] frame;
    logic        frame_valid;
    logic        frame_ready;
    logic [7:0]  blink_mask;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic        frame_done;

    seg_scan_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
`ifdef SEG_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .seg_en      (seg_en),
        .seg_out     (seg_out),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycle index since reset release and the two buffers.
    int          cyc   = 0;
    bit          armed = 0;
    logic [63:0] m_active, m_pending, prev_active;
    bit          m_full;
    logic [7:0]  prev_mask;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, got, want);
        end
    endtask

    // Model and per-cycle compare, evaluated mid-cycle on the falling edge.
    always @(negedge clk) begin
        logic [7:0] e_en, e_out;
        logic       e_done;
        int         t, c, d;
        if (armed) begin
            e_en  = 8'hFF;
            e_out = 8'h00;
            if (cyc > 0) begin
                t = cyc - 1;
                c = t % SCAN_DIV;
                d = (t / SCAN_DIV) % 8;
                if (c >= BLANK_CYC) begin
                    e_en  = ~(8'h01 << d);
                    e_out = prev_active[8*d +: 8];
`ifdef SEG_BLINK_EN
                    if (((t / BLINK_DIV) % 2) == 1 && prev_mask[d]) e_out = 8'h00;
`endif
                end
            end
            e_done = ((cyc % FRAME_CYC) == FRAME_CYC - 1);
            check("seg_en", {56'd0, seg_en}, {56'd0, e_en});
            check("seg_out", {56'd0, seg_out}, {56'd0, e_out});
            check("frame_done", {63'd0, frame_done}, {63'd0, e_done});
            check("frame_ready", {63'd0, frame_ready}, {63'd0, !m_full});
        end
        prev_active = m_active;
        prev_mask   = blink_mask;
        if (rst) begin
            m_active  = '0;
            m_pending = '0;
            m_full    = 0;
            cyc       = 0;
            armed     = 1;
        end else if (armed) begin
            if (frame_valid && !m_full) begin
                m_pending = frame;
                m_full    = 1;
            end else if (((cyc % FRAME_CYC) == FRAME_CYC - 1) && m_full) begin
                m_active = m_pending;
                m_full   = 0;
            end
            cyc++;
        end
    end

    // Advance to posedge+1 of the given cycle, bounded.
    task automatic wait_cycle(input int target);
        int guard = 0;
        while (cyc != target) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 5000) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_cycle timeout: at cycle %0d, want %0d", cyc, target);
                return;
            end
        end
    endtask

    // One-cycle reset pulse; returns at posedge+1 of the new cycle 0.
    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [63:0] F1 = 64'h0706050403020100;
    localparam logic [63:0] F2 = 64'h1122334455667788;
    localparam logic [63:0] F3 = 64'hA1B2C3D4E5F60718;
    localparam logic [63:0] F4 = 64'h0F1E2D3C4B5A6978;
    localparam logic [63:0] F5 = 64'hDEADBEEFCAFEF00D;

    initial begin
        rst         = 1'b1;
        frame       = '0;
        frame_valid = 1'b0;
        blink_mask  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset release with no frames.
        wait_cycle(0);
        check("lit_rst_en", {56'd0, seg_en}, 64'hFF);
        check("lit_rst_ready", {63'd0, frame_ready}, 64'd1);
        check("lit_rst_done", {63'd0, frame_done}, 64'd0);
        wait_cycle(2);
        check("lit_c2_en", {56'd0, seg_en}, 64'hFF);
        wait_cycle(3);
        check("lit_c3_en", {56'd0, seg_en}, 64'hFE);
        check("lit_c3_out", {56'd0, seg_out}, 64'h00);

        // First frame accepted at cycle 5.
        wait_cycle(5);
        frame       = F1;
        frame_valid = 1'b1;
        wait_cycle(6);
        frame_valid = 1'b0;
        check("lit_c6_ready", {63'd0, frame_ready}, 64'd0);
        wait_cycle(8);
        check("lit_c8_en", {56'd0, seg_en}, 64'hFE);
        wait_cycle(9);
        check("lit_c9_en", {56'd0, seg_en}, 64'hFF);
        wait_cycle(62);
        check("lit_c62_done", {63'd0, frame_done}, 64'd0);
        wait_cycle(63);
        check("lit_c63_done", {63'd0, frame_done}, 64'd1);
        check("lit_c63_ready", {63'd0, frame_ready}, 64'd0);
        wait_cycle(64);
        check("lit_c64_ready", {63'd0, frame_ready}, 64'd1);

        // Second frame fills pending; a third stalls until the boundary.
        wait_cycle(70);
        frame       = F2;
        frame_valid = 1'b1;
        wait_cycle(71);
        frame_valid = 1'b0;
        check("lit_c71_ready", {63'd0, frame_ready}, 64'd0);
        wait_cycle(80);
        frame       = F3;
        frame_valid = 1'b1;
        wait_cycle(91);
        check("lit_c91_en", {56'd0, seg_en}, 64'hF7);
        check("lit_c91_out", {56'd0, seg_out}, 64'h03);
        wait_cycle(100);
        check("lit_c100_ready", {63'd0, frame_ready}, 64'd0);
        wait_cycle(128);
        check("lit_c128_ready", {63'd0, frame_ready}, 64'd1);
        wait_cycle(129);
        frame_valid = 1'b0;
        check("lit_c129_ready", {63'd0, frame_ready}, 64'd0);
        wait_cycle(131);
        check("lit_c131_out", {56'd0, seg_out}, 64'h88);
        wait_cycle(195);
        check("lit_c195_out", {56'd0, seg_out}, 64'h18);

        // Handshake exactly on the boundary with pending empty.
        wait_cycle(255);
        check("lit_c255_done", {63'd0, frame_done}, 64'd1);
        check("lit_c255_ready", {63'd0, frame_ready}, 64'd1);
        frame       = F4;
        frame_valid = 1'b1;
        wait_cycle(256);
        frame_valid = 1'b0;
        check("lit_c256_ready", {63'd0, frame_ready}, 64'd0);
        wait_cycle(259);
        check("lit_c259_out", {56'd0, seg_out}, 64'h18);
        wait_cycle(323);
        check("lit_c323_out", {56'd0, seg_out}, 64'h78);

        // Randomized traffic against the model.
        for (int i = 330; i < 1100; i++) begin
            wait_cycle(i);
            frame       = {$urandom, $urandom};
            frame_valid = ($urandom_range(0, 2) == 0);
            blink_mask  = 8'($urandom);
        end
        wait_cycle(1100);
        frame_valid = 1'b0;
        blink_mask  = 8'h00;

        // Reset with a frame pending discards it.
        pulse_reset();
        wait_cycle(5);
        frame       = F5;
        frame_valid = 1'b1;
        wait_cycle(6);
        frame_valid = 1'b0;
        wait_cycle(20);
        check("lit_r20_ready", {63'd0, frame_ready}, 64'd0);
        pulse_reset();
        check("lit_r0_en", {56'd0, seg_en}, 64'hFF);
        check("lit_r0_out", {56'd0, seg_out}, 64'h00);
        check("lit_r0_ready", {63'd0, frame_ready}, 64'd1);
        wait_cycle(67);
        check("lit_r67_en", {56'd0, seg_en}, 64'hFE);
        check("lit_r67_out", {56'd0, seg_out}, 64'h00);
        wait_cycle(200);

`ifdef SEG_BLINK_EN
        // Blink digit 2 on an all-lit frame.
        pulse_reset();
        blink_mask = 8'h04;
        wait_cycle(5);
        frame       = {8{8'hFF}};
        frame_valid = 1'b1;
        wait_cycle(6);
        frame_valid = 1'b0;
        wait_cycle(85);
        check("lit_b85_en", {56'd0, seg_en}, 64'hFB);
        check("lit_b85_out", {56'd0, seg_out}, 64'h00);
        wait_cycle(93);
        check("lit_b93_out", {56'd0, seg_out}, 64'hFF);
        wait_cycle(149);
        check("lit_b149_out", {56'd0, seg_out}, 64'hFF);
        wait_cycle(200);
`endif

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
